// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter/sequencer for the external 16-bit SRAM, with bus turnaround and tagged reads.
// Build macro SRAM_ARB_FAIRNESS_EN enables the port-1 wait counter that force-grants after MAX_WAIT cycles.
module sram_arbiter #(
  parameter int MAX_WAIT = 16,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_p0_req,
  input  logic              i_p0_we,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_wdata,
  input  logic              i_p1_req,
  input  logic              i_p1_we,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_wdata,
  output logic              o_p0_gnt,
  output logic              o_p1_gnt,
  output logic              o_p0_rvalid,
  output logic              o_p1_rvalid,
  output logic [DATA_W-1:0] o_p0_rdata,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("sram_arbiter: MAX_WAIT must be within 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TURN} state_t;

  state_t            state, state_nxt;
  logic              p1_urgent;
  logic              win_p1, win_req, win_we, turn_block, accept;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

`ifdef SRAM_ARB_FAIRNESS_EN
  logic [7:0] wait_cnt;

  // Saturating count of cycles port 1 has been kept waiting
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_p1_req || o_p1_gnt) wait_cnt <= '0;
    else if (wait_cnt != 8'hFF)          wait_cnt <= wait_cnt + 8'd1;
  end

  assign p1_urgent = (wait_cnt >= 8'(MAX_WAIT));
`else
  assign p1_urgent = 1'b0;
`endif

  always_comb begin
    win_req    = i_p0_req || i_p1_req;
    win_p1     = i_p1_req && (!i_p0_req || p1_urgent);
    win_we     = win_p1 ? i_p1_we    : i_p0_we;
    win_addr   = win_p1 ? i_p1_addr  : i_p0_addr;
    win_wdata  = win_p1 ? i_p1_wdata : i_p0_wdata;
    // A direction change right after an access needs one dead bus cycle
    turn_block = ((state == S_RD) && win_we) || ((state == S_WR) && !win_we);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    if (win_req) begin
      if (turn_block) state_nxt = S_TURN;
      else            state_nxt = win_we ? S_WR : S_RD;
    end
  end

  always_comb begin
    o_p0_gnt = 1'b0;
    o_p1_gnt = 1'b0;
    if (!i_rst && win_req && !turn_block) begin
      o_p0_gnt = !win_p1;
      o_p1_gnt = win_p1;
    end
  end

  assign accept = o_p0_gnt || o_p1_gnt;

  // Stage 0: issue to SRAM pins
  logic              vld_p0, tag_p0, drive_p0;
  logic [DATA_W-1:0] wdata_p0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_SRAM_ADDR <= '0;
      o_SRAM_WE_N <= 1'b1;
      drive_p0    <= 1'b0;
      vld_p0      <= 1'b0;
    end else begin
      o_SRAM_WE_N <= !(accept && win_we);
      drive_p0    <= accept && win_we;
      vld_p0      <= accept && !win_we;
      if (accept) o_SRAM_ADDR <= win_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      wdata_p0 <= win_wdata;
      tag_p0   <= win_p1;
    end
  end

  assign io_SRAM_DQ = drive_p0 ? wdata_p0 : {DATA_W{1'bz}};

  // Stage 1: SRAM access in flight
  logic vld_p1, tag_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  always_ff @(posedge i_clk) begin
    tag_p1 <= tag_p0;
  end

  // Stage 2: sample DQ and return to the owning port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_p0_rvalid <= 1'b0;
      o_p1_rvalid <= 1'b0;
      o_p0_rdata  <= '0;
      o_p1_rdata  <= '0;
    end else begin
      o_p0_rvalid <= vld_p1 && !tag_p1;
      o_p1_rvalid <= vld_p1 && tag_p1;
      if (vld_p1 && !tag_p1) o_p0_rdata <= io_SRAM_DQ;
      if (vld_p1 && tag_p1)  o_p1_rdata <= io_SRAM_DQ;
    end
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer for the single external 16-bit SRAM. It sits between `Main`'s internal requesters and the SRAM pins: port 0 is the VGA render fetch path (latency-critical), port 1 is the frame/sprite writer (image rotation, scene preparation). It serialises their accesses, drives the SRAM address, write-enable and tri-state data bus, inserts bus turnaround cycles, and returns read data tagged to the owning port.

## Interface
- `MAX_WAIT`, 16: cycles port 1 may wait while requesting before it is force-granted (fairness build only); legal 1..255.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_p0_req`, `i_p1_req`  in  1  access request; must hold stable with its fields until granted.
- `i_p0_we`, `i_p1_we`  in  1  1 = write, 0 = read.
- `i_p0_addr`, `i_p1_addr`  in  20  word address.
- `i_p0_wdata`, `i_p1_wdata`  in  16  write data.
- `o_p0_gnt`, `o_p1_gnt`  out  1  combinational accept; the request is accepted on the edge where `req & gnt` = 1.
- `o_p0_rvalid`, `o_p1_rvalid`  out  1  one-cycle pulse: `o_pN_rdata` is valid.
- `o_p0_rdata`, `o_p1_rdata`  out  16  read data, held until the next rvalid for that port.
- `o_SRAM_ADDR`  out  20  SRAM address, registered.
- `io_SRAM_DQ`  inout  16  SRAM data; driven only during write cycles, otherwise Z.
- `o_SRAM_WE_N`  out  1  SRAM write enable, active low, registered.

## Operation
- FSM states: IDLE (bus unused last cycle), RD (read issued last cycle), WR (write issued last cycle), TURN (forced gap).
- Grant: at most one `gnt` high per cycle. Default is fixed priority: port 0 over port 1.
- Turnaround: if the winning request's direction differs from the op issued in the previous cycle (state RD→write or WR→read), no grant is given this cycle. The FSM enters TURN and grants in the following cycle. From IDLE or TURN, either direction is granted immediately.
- Same-direction back-to-back accesses run at full rate: one access per cycle.
- Read: a tag register records the owning port. The tag travels through a 2-stage pipeline alongside the valid bit.
- Write: `io_SRAM_DQ` = wdata and `o_SRAM_WE_N` = 0 for exactly the cycle after acceptance.
- Reset (`i_rst` = 1 at an edge):
  - State → IDLE, `o_SRAM_ADDR` = 0, `o_SRAM_WE_N` = 1, DQ released, both `gnt` = 0 while `i_rst` is high.
  - Both `rvalid` = 0, both `rdata` = 0, wait counter = 0.
  - In-flight reads are dropped: no rvalid is produced for them after reset.
- Idle: `o_SRAM_ADDR` holds its last value, `o_SRAM_WE_N` = 1, DQ = Z.

## Timing
- Accept on edge k: after edge k, `o_SRAM_ADDR` = address. For a write, `o_SRAM_WE_N` = 0 and DQ is driven during cycle k..k+1.
- Read: SRAM returns data during cycle k+1..k+2. The arbiter samples DQ at edge k+2, and `o_pN_rvalid` = 1 for cycle k+2..k+3. Read latency is 2 cycles; reads are fully pipelined.
- Write: `o_SRAM_WE_N` returns to 1 after edge k+1 unless another write is accepted at edge k+1.
- Direction change costs exactly 1 idle bus cycle; DQ is never driven in a cycle where SRAM read data is expected.
- Simultaneous requests with equal direction: port 0 wins (default build).

## Configuration
- `SRAM_ARB_FAIRNESS_EN` defined:
  - An 8-bit counter increments each cycle `i_p1_req` = 1 and port 1 is not granted.
  - When the counter ≥ `MAX_WAIT`, port 1 wins the next grant opportunity over port 0. Turnaround rules still apply.
  - The counter clears on port-1 acceptance or when `i_p1_req` = 0.
- Not defined: strict port-0 priority, and port 1 may starve indefinitely. No counter logic is present.

## Test plan
- Port 0 reads 0x00010 then 0x00011 back-to-back (SRAM preloaded 0xAAAA, 0x5555) → grants on consecutive edges; `o_p0_rvalid` high 2 cycles after each accept with 0xAAAA then 0x5555.
- Port 1 writes 0x1234 to 0x80000, then port 0 reads 0x80000 → exactly one TURN cycle with no grant; `o_SRAM_WE_N` low for one cycle; read returns 0x1234.
- Both ports request reads every cycle (default build) → only `o_p0_gnt` asserted and `o_p1_gnt` stays 0 for 100 cycles. With `SRAM_ARB_FAIRNESS_EN` and `MAX_WAIT` = 16 → `o_p1_gnt` asserts on the 17th cycle of waiting, then the counter is 0.
- Port 0 read and port 1 write alternate continuously → one access per 2 cycles; DQ never driven while a read sample is pending; every rvalid carries the correct port tag.
- Assert `i_rst` for 1 cycle one cycle after a read accept → no `o_p0_rvalid` afterwards; all outputs at their reset values; the next request is granted in the first cycle after reset.
